// File: rtl/dcache_pkg.sv
// Shared types and address-field constants for the direct-mapped data-cache controller.
package dcache_pkg;
  localparam int TAG_W      = 20;
  localparam int IDX_W      = 7;
  localparam int OFF_W      = 5;
  localparam int LINE_WORDS = 8;
  localparam int WORD_W     = $clog2(LINE_WORDS);
  localparam int PERF_W     = 32;

  // Address slice positions: tag[31:TAG_LSB], idx[TAG_LSB-1:IDX_LSB], word[IDX_LSB-1:WORD_LSB]
  localparam int WORD_LSB = 2;
  localparam int IDX_LSB  = OFF_W;
  localparam int TAG_LSB  = OFF_W + IDX_W;

  typedef enum logic [2:0] {
    S_IDLE, S_LOOKUP, S_WB_REQ, S_WB_DATA, S_RF_REQ, S_RF_DATA, S_RESP
  } state_t;

  typedef struct packed {
    logic        wr;
    logic [31:0] addr;
    logic [3:0]  wstrb;
    logic [31:0] wdata;
  } req_t;

  function automatic logic [31:0] merge_bytes(input logic [31:0] base,
                                              input logic [31:0] wdata,
                                              input logic [3:0]  strb);
    logic [31:0] r;
    r = base;
    for (int b = 0; b < 4; b++)
      if (strb[b]) r[8*b +: 8] = wdata[8*b +: 8];
    return r;
  endfunction
endpackage

// File: rtl/dcache_perf_cnt.sv
// Hit/miss event counters; only instantiated when DCACHE_PERF_CNT_EN is defined.
module dcache_perf_cnt (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         hit_evt,
  input  logic                         miss_evt,
  output logic [dcache_pkg::PERF_W-1:0] perf_hit,
  output logic [dcache_pkg::PERF_W-1:0] perf_miss
);
  import dcache_pkg::*;

  always_ff @(posedge clk) begin
    if (rst) begin
      perf_hit  <= '0;
      perf_miss <= '0;
    end else begin
      if (hit_evt)  perf_hit  <= perf_hit + 1'b1;
      if (miss_evt) perf_miss <= perf_miss + 1'b1;
    end
  end
endmodule

// File: rtl/dcache_ctrl.sv
// Direct-mapped data-cache controller: hit service, dirty write-back, line refill.
// Optional hit/miss counters are built when DCACHE_PERF_CNT_EN is defined.
module dcache_ctrl #(
  parameter int TAG_W      = dcache_pkg::TAG_W,
  parameter int IDX_W      = dcache_pkg::IDX_W,
  parameter int LINE_WORDS = dcache_pkg::LINE_WORDS
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic                  req_wr,
  input  logic [31:0]           req_addr,
  input  logic [3:0]            req_wstrb,
  input  logic [31:0]           req_wdata,
  output logic                  resp_valid,
  output logic [31:0]           resp_rdata,
  output logic [IDX_W-1:0]      qidx,
  output logic [TAG_W-1:0]      tag_query,
  input  logic                  hit,
  input  logic [TAG_W-1:0]      tag_out,
  input  logic                  valid_out,
  input  logic                  dirty_out,
  output logic                  tag_wen,
  output logic                  valid_wen,
  output logic                  dirty_wen,
  output logic [IDX_W-1:0]      widx,
  output logic [TAG_W-1:0]      tag_write,
  output logic                  valid_in,
  output logic                  dirty_in,
  output logic [IDX_W+$clog2(LINE_WORDS)-1:0] data_addr,
  output logic [3:0]            data_wen,
  output logic [31:0]           data_wdata,
  input  logic [31:0]           data_rdata,
  output logic                  mem_rd_req,
  input  logic                  mem_rd_ready,
  output logic [31:0]           mem_rd_addr,
  input  logic                  mem_rd_valid,
  input  logic [31:0]           mem_rd_data,
  input  logic                  mem_rd_last,
  output logic                  mem_wr_req,
  input  logic                  mem_wr_ready,
  output logic [31:0]           mem_wr_addr,
  output logic                  mem_wr_valid,
  output logic [31:0]           mem_wr_data,
  output logic                  mem_wr_last
`ifdef DCACHE_PERF_CNT_EN
  ,
  output logic [31:0]           perf_hit,
  output logic [31:0]           perf_miss
`endif
);
  import dcache_pkg::*;

  localparam int WB   = $clog2(LINE_WORDS);
  localparam int TPOS = OFF_W + IDX_W;
  localparam logic [WB-1:0] LAST_BEAT = WB'(LINE_WORDS - 1);

  state_t         state, state_nx;
  req_t           req_q;
  logic [TAG_W-1:0] victim_q;
  logic [WB-1:0]  beat_q;
  logic [WB-1:0]  beat_inc;
  logic [31:0]    rdata_q;

  logic [TAG_W-1:0] tag_q;
  logic [IDX_W-1:0] idx_q;
  logic [WB-1:0]    word_q;
  logic             wr_last;
  logic             rf_last;

  assign tag_q    = req_q.addr[TPOS +: TAG_W];
  assign idx_q    = req_q.addr[IDX_LSB +: IDX_W];
  assign word_q   = req_q.addr[WORD_LSB +: WB];
  assign beat_inc = beat_q + 1'b1;
  assign wr_last  = (beat_q == LAST_BEAT);
  assign rf_last  = mem_rd_last || (beat_q == LAST_BEAT);

  // Byte-offset bits never address anything inside the word array.
  logic unused_addr_bits;
  assign unused_addr_bits = ^{req_q.addr[1:0], req_addr[1:0]};

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= S_IDLE;
      req_q    <= '0;
      victim_q <= '0;
      beat_q   <= '0;
      rdata_q  <= '0;
    end else begin
      state <= state_nx;
      case (state)
        S_IDLE:
          if (req_valid) begin
            req_q.wr    <= req_wr;
            req_q.addr  <= req_addr;
            req_q.wstrb <= req_wstrb;
            req_q.wdata <= req_wdata;
          end
        S_LOOKUP:
          if (!hit && valid_out && dirty_out) victim_q <= tag_out;
        S_WB_DATA:
          if (mem_wr_ready) beat_q <= wr_last ? '0 : beat_inc;
        S_RF_DATA:
          if (mem_rd_valid) begin
            beat_q <= rf_last ? '0 : beat_inc;
            if (!req_q.wr && beat_q == word_q) rdata_q <= mem_rd_data;
          end
        default: ;
      endcase
    end
  end

  always_comb begin
    state_nx     = state;
    req_ready    = 1'b0;
    resp_valid   = 1'b0;
    resp_rdata   = '0;
    qidx         = idx_q;
    tag_query    = tag_q;
    tag_wen      = 1'b0;
    valid_wen    = 1'b0;
    dirty_wen    = 1'b0;
    widx         = '0;
    tag_write    = '0;
    valid_in     = 1'b0;
    dirty_in     = 1'b0;
    data_addr    = {idx_q, word_q};
    data_wen     = '0;
    data_wdata   = '0;
    mem_rd_req   = 1'b0;
    mem_rd_addr  = '0;
    mem_wr_req   = 1'b0;
    mem_wr_addr  = '0;
    mem_wr_valid = 1'b0;
    mem_wr_data  = '0;
    mem_wr_last  = 1'b0;
    case (state)
      S_IDLE: begin
        // Query and data read issue straight from the request so a hit answers next cycle.
        req_ready = 1'b1;
        qidx      = req_addr[IDX_LSB +: IDX_W];
        tag_query = req_addr[TPOS +: TAG_W];
        data_addr = {req_addr[IDX_LSB +: IDX_W], req_addr[WORD_LSB +: WB]};
        if (req_valid) state_nx = S_LOOKUP;
      end
      S_LOOKUP: begin
        if (hit) begin
          resp_valid = 1'b1;
          state_nx   = S_IDLE;
          if (req_q.wr) begin
            data_wen   = req_q.wstrb;
            data_wdata = req_q.wdata;
            dirty_wen  = 1'b1;
            dirty_in   = 1'b1;
            widx       = idx_q;
          end else begin
            resp_rdata = data_rdata;
          end
        end else if (valid_out && dirty_out) begin
          state_nx = S_WB_REQ;
        end else begin
          state_nx = S_RF_REQ;
        end
      end
      S_WB_REQ: begin
        mem_wr_req  = 1'b1;
        mem_wr_addr = {victim_q, idx_q, {OFF_W{1'b0}}};
        data_addr   = {idx_q, {WB{1'b0}}};
        if (mem_wr_ready) state_nx = S_WB_DATA;
      end
      S_WB_DATA: begin
        // Read one word ahead only when the current beat is taken; a stall re-reads the same word.
        mem_wr_valid = 1'b1;
        mem_wr_addr  = {victim_q, idx_q, {OFF_W{1'b0}}};
        mem_wr_data  = data_rdata;
        mem_wr_last  = wr_last;
        data_addr    = {idx_q, mem_wr_ready ? beat_inc : beat_q};
        if (mem_wr_ready && wr_last) state_nx = S_RF_REQ;
      end
      S_RF_REQ: begin
        mem_rd_req  = 1'b1;
        mem_rd_addr = {tag_q, idx_q, {OFF_W{1'b0}}};
        if (mem_rd_ready) state_nx = S_RF_DATA;
      end
      S_RF_DATA: begin
        data_addr = {idx_q, beat_q};
        if (mem_rd_valid) begin
          data_wen   = 4'hF;
          data_wdata = (req_q.wr && beat_q == word_q)
                     ? merge_bytes(mem_rd_data, req_q.wdata, req_q.wstrb)
                     : mem_rd_data;
          if (rf_last) begin
            tag_wen   = 1'b1;
            valid_wen = 1'b1;
            dirty_wen = 1'b1;
            widx      = idx_q;
            tag_write = tag_q;
            valid_in  = 1'b1;
            dirty_in  = req_q.wr;
            state_nx  = S_RESP;
          end
        end
      end
      S_RESP: begin
        resp_valid = 1'b1;
        resp_rdata = req_q.wr ? '0 : rdata_q;
        state_nx   = S_IDLE;
      end
      default: state_nx = S_IDLE;
    endcase
  end

`ifdef DCACHE_PERF_CNT_EN
  dcache_perf_cnt u_perf (
    .clk      (clk),
    .rst      (rst),
    .hit_evt  (state == S_LOOKUP && hit),
    .miss_evt (state == S_LOOKUP && !hit),
    .perf_hit (perf_hit),
    .perf_miss(perf_miss)
  );
`endif
endmodule

// File: tb/tb_dcache_ctrl.sv
// Directed bench for dcache_ctrl with behavioural tag array, data array and burst memory.
module tb_dcache_ctrl;
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst, req_valid, req_ready, req_wr;
  logic [31:0] req_addr, req_wdata, resp_rdata;
  logic [3:0]  req_wstrb;
  logic        resp_valid;
  logic [6:0]  qidx, widx;
  logic [19:0] tag_query, tag_out, tag_write;
  logic        hit, valid_out, dirty_out;
  logic        tag_wen, valid_wen, dirty_wen, valid_in, dirty_in;
  logic [9:0]  data_addr;
  logic [3:0]  data_wen;
  logic [31:0] data_wdata, data_rdata;
  logic        mem_rd_req, mem_rd_ready, mem_rd_valid, mem_rd_last;
  logic [31:0] mem_rd_addr, mem_rd_data;
  logic        mem_wr_req, mem_wr_ready, mem_wr_valid, mem_wr_last;
  logic [31:0] mem_wr_addr, mem_wr_data;
`ifdef DCACHE_PERF_CNT_EN
  logic [31:0] perf_hit, perf_miss;
`endif

  int checks = 0;
  int errors = 0;

  dcache_ctrl dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready), .req_wr(req_wr),
    .req_addr(req_addr), .req_wstrb(req_wstrb), .req_wdata(req_wdata),
    .resp_valid(resp_valid), .resp_rdata(resp_rdata),
    .qidx(qidx), .tag_query(tag_query), .hit(hit), .tag_out(tag_out),
    .valid_out(valid_out), .dirty_out(dirty_out),
    .tag_wen(tag_wen), .valid_wen(valid_wen), .dirty_wen(dirty_wen),
    .widx(widx), .tag_write(tag_write), .valid_in(valid_in), .dirty_in(dirty_in),
    .data_addr(data_addr), .data_wen(data_wen), .data_wdata(data_wdata),
    .data_rdata(data_rdata),
    .mem_rd_req(mem_rd_req), .mem_rd_ready(mem_rd_ready), .mem_rd_addr(mem_rd_addr),
    .mem_rd_valid(mem_rd_valid), .mem_rd_data(mem_rd_data), .mem_rd_last(mem_rd_last),
    .mem_wr_req(mem_wr_req), .mem_wr_ready(mem_wr_ready), .mem_wr_addr(mem_wr_addr),
    .mem_wr_valid(mem_wr_valid), .mem_wr_data(mem_wr_data), .mem_wr_last(mem_wr_last)
`ifdef DCACHE_PERF_CNT_EN
    , .perf_hit(perf_hit), .perf_miss(perf_miss)
`endif
  );

  // Tag array: registered hit, combinational readout.
  logic [19:0] tag_a [128];
  logic        val_a [128];
  logic        dty_a [128];
  assign tag_out   = tag_a[qidx];
  assign valid_out = val_a[qidx];
  assign dirty_out = dty_a[qidx];
  always @(posedge clk) begin
    hit <= val_a[qidx] && (tag_a[qidx] == tag_query);
    if (rst) begin
      for (int i = 0; i < 128; i++) val_a[i] <= 1'b0;
    end else begin
      if (tag_wen)   tag_a[widx] <= tag_write;
      if (valid_wen) val_a[widx] <= valid_in;
      if (dirty_wen) dty_a[widx] <= dirty_in;
    end
  end

  // Data array: synchronous read, byte-enable write.
  logic [31:0] dmem [1024];
  always @(posedge clk) begin
    data_rdata <= dmem[data_addr];
    for (int b = 0; b < 4; b++)
      if (data_wen[b]) dmem[data_addr][8*b +: 8] <= data_wdata[8*b +: 8];
  end

  // Burst memory responder and monitor; state written only here, knobs only by tests.
  logic [31:0] rd_pat;
  int          stall_beat, stall_len;
  int          rd_phase, rd_k, rd_beat, rd_req_cnt, wr_req_cnt, wr_cnt;
  int          stall_done, unstable, tw_cnt, mem_act;
  logic [31:0] rd_addr_log, wr_addr_log, stall_val;
  logic        stall_seen;
  logic [31:0] wr_log [16];
  logic [15:0] wr_last_mask;
  logic [19:0] tw_tag;
  logic [6:0]  tw_idx;
  logic        tw_valid, tw_dirty;

  initial begin : mem_model
    rd_phase = 0; rd_k = 0; rd_beat = -1; rd_req_cnt = 0; wr_req_cnt = 0; wr_cnt = 0;
    stall_done = 0; unstable = 0; tw_cnt = 0; mem_act = 0; stall_seen = 0;
    rd_addr_log = '0; wr_addr_log = '0; stall_val = '0; wr_last_mask = '0;
    tw_tag = '0; tw_idx = '0; tw_valid = 0; tw_dirty = 0;
    mem_rd_ready = 0; mem_rd_valid = 0; mem_rd_last = 0; mem_rd_data = '0; mem_wr_ready = 0;
    forever begin
      @(negedge clk);
      if (tag_wen === 1'b1) begin
        tw_cnt++; tw_tag = tag_write; tw_idx = widx; tw_valid = valid_in; tw_dirty = dirty_in;
      end
      if (mem_rd_req || mem_wr_req || mem_wr_valid) mem_act++;
      mem_rd_ready = 0; mem_rd_valid = 0; mem_rd_last = 0; mem_rd_data = '0; mem_wr_ready = 0;
      if (rst) begin
        rd_phase = 0; rd_beat = -1;
      end else begin
        if (rd_phase == 0 && mem_rd_req) begin
          mem_rd_ready = 1; rd_addr_log = mem_rd_addr; rd_req_cnt++; rd_phase = 1; rd_k = 0;
        end else if (rd_phase == 1) begin
          mem_rd_valid = 1; mem_rd_data = rd_pat + rd_k; mem_rd_last = (rd_k == 7);
          rd_beat = rd_k; rd_k++;
          if (rd_k == 8) rd_phase = 0;
        end
        if (mem_wr_req) begin
          mem_wr_ready = 1; wr_addr_log = mem_wr_addr; wr_req_cnt++;
          wr_cnt = 0; wr_last_mask = '0; stall_done = 0; unstable = 0; stall_seen = 0;
        end else if (mem_wr_valid) begin
          if (stall_seen && wr_cnt == stall_beat && mem_wr_data !== stall_val) unstable++;
          if (wr_cnt == stall_beat && stall_done < stall_len) begin
            stall_done++; stall_seen = 1; stall_val = mem_wr_data;
          end else begin
            mem_wr_ready = 1;
            if (wr_cnt < 16) begin
              wr_log[wr_cnt] = mem_wr_data;
              wr_last_mask[wr_cnt] = mem_wr_last;
            end
            wr_cnt++;
          end
        end
      end
    end
  end

  task automatic do_req(input logic wr, input logic [31:0] addr,
                        input logic [3:0] strb, input logic [31:0] wd);
    @(negedge clk); #1;
    req_valid = 1; req_wr = wr; req_addr = addr; req_wstrb = strb; req_wdata = wd;
    @(negedge clk); #1;
    req_valid = 0;
  endtask

  task automatic wait_resp(output int n, output logic [31:0] rd);
    n = -1; rd = '0;
    for (int i = 0; i < 200; i++) begin
      if (resp_valid === 1'b1) begin n = i; rd = resp_rdata; break; end
      @(negedge clk); #1;
    end
  endtask

  task automatic test_reset();
    rst = 1; req_valid = 0; req_wr = 0; req_addr = '0; req_wstrb = '0; req_wdata = '0;
    stall_beat = 0; stall_len = 0; rd_pat = '0;
    repeat (3) @(posedge clk);
    @(negedge clk); #1;
    checks++; if (req_ready !== 1'b1) begin errors++; $display("FAIL reset_ready got %b exp 1", req_ready); end
    checks++; if ({resp_valid, mem_rd_req, mem_wr_req, mem_wr_valid, tag_wen, dirty_wen} !== 6'b0)
      begin errors++; $display("FAIL reset_ctl got %b exp 000000",
        {resp_valid, mem_rd_req, mem_wr_req, mem_wr_valid, tag_wen, dirty_wen}); end
    checks++; if (data_wen !== 4'h0 || data_addr !== 10'h0) begin errors++;
      $display("FAIL reset_data got wen=%h addr=%h exp 0/0", data_wen, data_addr); end
    rst = 0;
  endtask

  task automatic test_load_miss();
    int n; logic [31:0] rd; int rq0, tw0, wq0;
    rq0 = rd_req_cnt; tw0 = tw_cnt; wq0 = wr_req_cnt; rd_pat = 32'hA0;
    do_req(0, 32'h0000_1040, 4'h0, '0);
    wait_resp(n, rd);
    checks++; if (n < 1) begin errors++; $display("FAIL miss_resp latency got %0d exp >=1", n); end
    checks++; if (rd !== 32'hA0) begin errors++; $display("FAIL miss_rdata got %h exp a0", rd); end
    checks++; if (rd_addr_log !== 32'h0000_1040 || rd_req_cnt != rq0 + 1) begin errors++;
      $display("FAIL miss_rd_addr got %h n=%0d exp 00001040 n=1", rd_addr_log, rd_req_cnt - rq0); end
    checks++; if (tw_cnt != tw0 + 1 || tw_tag !== 20'h00001 || tw_idx !== 7'd2 || tw_valid !== 1'b1 || tw_dirty !== 1'b0)
      begin errors++; $display("FAIL miss_tagwr got n=%0d tag=%h idx=%0d v=%b d=%b exp 1/00001/2/1/0",
        tw_cnt - tw0, tw_tag, tw_idx, tw_valid, tw_dirty); end
    checks++; if (wr_req_cnt != wq0) begin errors++; $display("FAIL miss_no_wb got %0d exp 0", wr_req_cnt - wq0); end
  endtask

  task automatic test_load_hit();
    int n; logic [31:0] rd; int a0;
    a0 = mem_act;
    do_req(0, 32'h0000_1044, 4'h0, '0);
    wait_resp(n, rd);
    checks++; if (n != 0) begin errors++; $display("FAIL hit_latency got %0d exp 0", n); end
    checks++; if (rd !== 32'hA1) begin errors++; $display("FAIL hit_rdata got %h exp a1", rd); end
    @(negedge clk); #1;
    checks++; if (mem_act != a0) begin errors++; $display("FAIL hit_mem_idle got %0d exp 0", mem_act - a0); end
  endtask

  task automatic test_store_hit();
    int n; logic [31:0] rd;
    do_req(1, 32'h0000_1048, 4'b0011, 32'hDEAD_BEEF);
    checks++; if (resp_valid !== 1'b1) begin errors++; $display("FAIL st_hit_resp got %b exp 1", resp_valid); end
    checks++; if (data_wen !== 4'b0011 || data_addr !== 10'h012 || data_wdata !== 32'hDEAD_BEEF) begin errors++;
      $display("FAIL st_hit_data got wen=%b addr=%h wd=%h exp 0011/012/deadbeef", data_wen, data_addr, data_wdata); end
    checks++; if (dirty_wen !== 1'b1 || dirty_in !== 1'b1 || widx !== 7'd2 || tag_wen !== 1'b0) begin errors++;
      $display("FAIL st_hit_dirty got dw=%b di=%b idx=%0d tw=%b exp 1/1/2/0", dirty_wen, dirty_in, widx, tag_wen); end
    wait_resp(n, rd);
    checks++; if (n != 0) begin errors++; $display("FAIL st_hit_latency got %0d exp 0", n); end
  endtask

  task automatic test_dirty_evict();
    int n; logic [31:0] rd; logic [31:0] exp;
    rd_pat = 32'hB0;
    do_req(0, 32'h0000_2040, 4'h0, '0);
    wait_resp(n, rd);
    checks++; if (n < 0) begin errors++; $display("FAIL evict_timeout got %0d exp >=0", n); end
    checks++; if (wr_addr_log !== 32'h0000_1040) begin errors++; $display("FAIL evict_wb_addr got %h exp 00001040", wr_addr_log); end
    checks++; if (wr_cnt != 8 || wr_last_mask !== 16'h0080) begin errors++;
      $display("FAIL evict_beats got n=%0d last=%h exp 8/0080", wr_cnt, wr_last_mask); end
    for (int k = 0; k < 8; k++) begin
      exp = (k == 2) ? 32'h0000_BEEF : 32'hA0 + k;
      checks++; if (wr_log[k] !== exp) begin errors++; $display("FAIL evict_beat%0d got %h exp %h", k, wr_log[k], exp); end
    end
    checks++; if (rd_addr_log !== 32'h0000_2040 || rd !== 32'hB0) begin errors++;
      $display("FAIL evict_refill got addr=%h rd=%h exp 00002040/b0", rd_addr_log, rd); end
    checks++; if (tw_tag !== 20'h00002 || tw_dirty !== 1'b0) begin errors++;
      $display("FAIL evict_tagwr got tag=%h d=%b exp 00002/0", tw_tag, tw_dirty); end
  endtask

  task automatic test_wb_stall();
    int n; logic [31:0] rd; logic [31:0] exp;
    do_req(1, 32'h0000_2044, 4'hF, 32'h1234_5678);
    wait_resp(n, rd);
    stall_beat = 3; stall_len = 3; rd_pat = 32'hC0;
    do_req(0, 32'h0000_3040, 4'h0, '0);
    wait_resp(n, rd);
    stall_len = 0;
    checks++; if (n < 0 || rd !== 32'hC0) begin errors++; $display("FAIL stall_resp got n=%0d rd=%h exp c0", n, rd); end
    checks++; if (wr_addr_log !== 32'h0000_2040) begin errors++; $display("FAIL stall_wb_addr got %h exp 00002040", wr_addr_log); end
    checks++; if (stall_done != 3 || unstable != 0) begin errors++;
      $display("FAIL stall_hold got stalls=%0d unstable=%0d exp 3/0", stall_done, unstable); end
    checks++; if (wr_cnt != 8 || wr_last_mask !== 16'h0080) begin errors++;
      $display("FAIL stall_beats got n=%0d last=%h exp 8/0080", wr_cnt, wr_last_mask); end
    for (int k = 0; k < 8; k++) begin
      exp = (k == 1) ? 32'h1234_5678 : 32'hB0 + k;
      checks++; if (wr_log[k] !== exp) begin errors++; $display("FAIL stall_beat%0d got %h exp %h", k, wr_log[k], exp); end
    end
  endtask

  task automatic test_store_miss_merge();
    int n; logic [31:0] rd; int wq0;
    wq0 = wr_req_cnt; rd_pat = 32'hD0;
    do_req(1, 32'h0000_4050, 4'b1100, 32'hCAFE_0000);
    wait_resp(n, rd);
    checks++; if (n < 0 || wr_req_cnt != wq0) begin errors++;
      $display("FAIL stmiss_flow got n=%0d wb=%0d exp >=0/0", n, wr_req_cnt - wq0); end
    checks++; if (tw_tag !== 20'h00004 || tw_dirty !== 1'b1) begin errors++;
      $display("FAIL stmiss_tagwr got tag=%h d=%b exp 00004/1", tw_tag, tw_dirty); end
    do_req(0, 32'h0000_4050, 4'h0, '0);
    wait_resp(n, rd);
    checks++; if (n != 0 || rd !== 32'hCAFE_00D4) begin errors++;
      $display("FAIL stmiss_merge got n=%0d rd=%h exp 0/cafe00d4", n, rd); end
`ifdef DCACHE_PERF_CNT_EN
    checks++; if (perf_hit !== 32'd4 || perf_miss !== 32'd4) begin errors++;
      $display("FAIL perf_cnt got h=%0d m=%0d exp 4/4", perf_hit, perf_miss); end
`endif
  endtask

  task automatic test_reset_mid_refill();
    int n; logic [31:0] rd; int tw0, rq0; logic found;
    tw0 = tw_cnt; rd_pat = 32'hE0; found = 0;
    do_req(0, 32'h0000_5060, 4'h0, '0);
    for (int i = 0; i < 100; i++) begin
      @(negedge clk); #2;
      if (mem_rd_valid && rd_beat == 4) begin found = 1; break; end
    end
    checks++; if (found !== 1'b1) begin errors++; $display("FAIL rstmid_beat4 got %b exp 1", found); end
    rst = 1;
    @(negedge clk); #1;
    checks++; if (req_ready !== 1'b1 || resp_valid !== 1'b0 || tag_wen !== 1'b0) begin errors++;
      $display("FAIL rstmid_idle got rdy=%b resp=%b tw=%b exp 1/0/0", req_ready, resp_valid, tag_wen); end
    rst = 0;
    @(negedge clk); #1;
    checks++; if (tw_cnt != tw0 || resp_valid !== 1'b0) begin errors++;
      $display("FAIL rstmid_no_tagwr got %0d resp=%b exp 0/0", tw_cnt - tw0, resp_valid); end
    rq0 = rd_req_cnt; rd_pat = 32'hF0;
    do_req(0, 32'h0000_5060, 4'h0, '0);
    wait_resp(n, rd);
    checks++; if (n < 1 || rd !== 32'hF0 || rd_req_cnt != rq0 + 1) begin errors++;
      $display("FAIL rstmid_retry got n=%0d rd=%h req=%0d exp >=1/f0/1", n, rd, rd_req_cnt - rq0); end
`ifdef DCACHE_PERF_CNT_EN
    checks++; if (perf_hit !== 32'd0 || perf_miss !== 32'd1) begin errors++;
      $display("FAIL perf_after_rst got h=%0d m=%0d exp 0/1", perf_hit, perf_miss); end
`endif
  endtask

  initial begin
    test_reset();
    test_load_miss();
    test_load_hit();
    test_store_hit();
    test_dirty_evict();
    test_wb_stall();
    test_store_miss_merge();
    test_reset_mid_refill();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/dcache_ctrl.md
Name: dcache_ctrl

Overview:
- Data-cache controller FSM; sits directly downstream of the dcache tag array.
- Drives the tag array's query and write ports and consumes its registered `hit` plus combinational `tag_out`/`valid_out`/`dirty_out`.
- Owns the data-array port and sequences load/store hits, dirty-victim write-back and line refill over a burst memory interface.
- Direct-mapped: 128 sets, 32-byte lines of 8 words, 32-bit address split tag[31:12], idx[11:5], word[4:2].

Parameters:
- TAG_W, 20, tag width
- IDX_W, 7, set index width
- LINE_WORDS, 8, 32-bit words per line (beat count)

Ports:
- clk  in  1  clock
- rst  in  1  reset
- req_valid  in  1  CPU request valid
- req_ready  out  1  request accepted when req_valid&&req_ready
- req_wr  in  1  1=store, 0=load
- req_addr  in  32  byte address
- req_wstrb  in  4  store byte enables
- req_wdata  in  32  store data
- resp_valid  out  1  one-cycle completion pulse
- resp_rdata  out  32  load data
- qidx  out  7  tag query index
- tag_query  out  20  tag to compare
- hit  in  1  registered hit, one cycle after query
- tag_out  in  20  stored tag at qidx (combinational)
- valid_out  in  1  stored valid at qidx
- dirty_out  in  1  stored dirty at qidx
- tag_wen, valid_wen, dirty_wen  out  1 each  tag-array write enables
- widx  out  7  tag-array write index
- tag_write  out  20  tag to write
- valid_in  out  1  valid value to write
- dirty_in  out  1  dirty value to write
- data_addr  out  10  data array {idx, word}, synchronous read (1-cycle latency)
- data_wen  out  4  data array byte enables
- data_wdata  out  32  data array write data
- data_rdata  in  32  data array read data
- mem_rd_req  out  1  refill request; held until mem_rd_ready
- mem_rd_ready  in  1  refill request accepted
- mem_rd_addr  out  32  line-aligned refill address
- mem_rd_valid  in  1  refill beat valid
- mem_rd_data  in  32  refill beat data
- mem_rd_last  in  1  final refill beat
- mem_wr_req  out  1  write-back request; held until mem_wr_ready
- mem_wr_ready  in  1  request accepted and per-beat ready
- mem_wr_addr  out  32  line-aligned write-back address
- mem_wr_valid  out  1  write-back beat valid
- mem_wr_data  out  32  write-back beat data
- mem_wr_last  out  1  final write-back beat

Behaviour:
- Clock and reset: single clock clk; reset rst is synchronous, active-high.
- Reset: state=IDLE; all outputs 0 except req_ready=1. Beat counter 0, captured request cleared.
- Reset mid-operation: abandons any burst immediately; the memory side shares the same rst.

State machine (IDLE, LOOKUP, WB_REQ, WB_DATA, RF_REQ, RF_DATA, RESP):
- IDLE:
  - req_ready=1; qidx=req_addr[11:5], tag_query=req_addr[31:12], data_addr={req_addr[11:5], req_addr[4:2]}, all combinational.
  - On accept: capture the request and go to LOOKUP.
- LOOKUP:
  - qidx/tag_query/data_addr driven from the captured request.
  - Load hit: resp_valid=1, resp_rdata=data_rdata → IDLE (latency: accept cycle T, response T+1).
  - Store hit: data_wen=req_wstrb, data_wdata=req_wdata; dirty_wen=1, dirty_in=1, widx=idx; resp_valid=1 → IDLE.
  - Miss with valid_out&&dirty_out: latch victim tag_out → WB_REQ.
  - Other miss → RF_REQ.
- WB_REQ:
  - mem_wr_req=1, mem_wr_addr={victim_tag, idx, 5'b0}; data_addr points at word 0 (prefetch).
  - On mem_wr_ready → WB_DATA.
- WB_DATA:
  - mem_wr_valid=1, mem_wr_data=data_rdata; on each mem_wr_ready the beat counter increments and data_addr advances to the next word.
  - mem_wr_last=1 on beat LINE_WORDS-1; after that beat is accepted → RF_REQ.
  - Stall (mem_wr_ready=0): hold data_addr and mem_wr_data stable.
- RF_REQ:
  - mem_rd_req=1, mem_rd_addr={tag, idx, 5'b0}; on mem_rd_ready → RF_DATA.
- RF_DATA:
  - Each mem_rd_valid beat k: data_addr={idx, k}, data_wen=4'hF, data_wdata=mem_rd_data.
  - If store and k==req word: merge req_wdata under req_wstrb.
  - If load and k==req word: capture the beat into resp_rdata.
  - Beat counter wraps 7→0.
  - On mem_rd_last (or k==LINE_WORDS-1): tag_wen=valid_wen=dirty_wen=1, tag_write=tag, valid_in=1, dirty_in=req_wr → RESP.
- RESP: resp_valid=1 for one cycle → IDLE. The next query to the same idx sees the new tag via the tag array's write-forwarding.
- Ordering and guarantees:
  - req_ready=0 outside IDLE; no hit-under-miss.
  - The tag array write in the last refill cycle never collides with a query.
  - mem_rd_valid outside RF_DATA is ignored.

Optional Feature:
- Macro DCACHE_PERF_CNT_EN. When defined, adds outputs perf_hit[31:0] and perf_miss[31:0].
- The counters increment in LOOKUP on hit and on miss respectively, clear on rst, and wrap at 2^32.
- When undefined, neither port nor counter logic exists.

Decomposition:
- Package dcache_pkg holds: TAG_W, IDX_W, OFF_W=5, LINE_WORDS, the address-field slice helpers as localparams, and the FSM state encoding.
- One natural sub-module: dcache_perf_cnt, instantiated only under DCACHE_PERF_CNT_EN.

Test Plan:
- Load to 0x0000_1040 after reset → miss, mem_rd_addr=0x0000_1040, 8 beats 0xA0..0xA7. Then resp_rdata=0xA0, tag_write=0x00001, valid_in=1, dirty_in=0.
- Repeat load of 0x0000_1044 → resp_valid at T+1, resp_rdata=0xA1, no mem_* activity.
- Store 0xDEADBEEF, wstrb=4'b0011, to 0x0000_1048 (hit) → data_wen=4'b0011, dirty_wen=1, dirty_in=1, resp at T+1.
- Load 0x0000_2040 (same idx, dirty victim) → mem_wr_addr=0x0000_1040, 8 write beats with beat 2 = 0xA2 low-half-merged BEEF. Then refill from 0x0000_2040 with dirty_in=0.
- Hold mem_wr_ready low for 3 cycles mid-burst → mem_wr_data stable, no beat lost or duplicated, mem_wr_last only on beat 7.
- Assert rst during RF_DATA beat 4 → next cycle state IDLE, req_ready=1, no tag_wen, resp_valid=0.
